// File: rtl/overlay_cmd_seq.sv
// overlay_cmd_seq
// -----------------------------------------------------------------------------
// Builds one overlay frame as a command list for the shared draw engine:
// one CLEAR of the bank being written, one RECT per valid box, then (when
// labels are compiled in) the label characters of every valid box. Each
// command is offered over a valid/ready handshake. The overlay RAM is
// ping-pong banked; o_disp_bank names the last completed bank.
//
// Optional feature macro: OVL_LABEL_EN
//   defined   : LABEL state exists and CHAR commands (type 2) are issued.
//   undefined : i_cls_str / i_rect_cls are ignored, RECT goes straight to DONE.
//
// Ports
//   sys_clk, sys_rst       clock, synchronous active-high reset
//   i_frame_start          one-cycle request to build the next frame
//   i_rect                 box k at [k*4*L_W +: 4*L_W], packed {x1,y1,x2,y2}
//   i_rect_vld             per-box valid
//   i_rect_cls             class of box k at [k*CLS_W +: CLS_W]
//   i_cls_str              label of class c, char 0 in the MSB byte, 0 ends
//   o_cmd_valid/i_cmd_ready command handshake
//   o_cmd_type             0 CLEAR, 1 RECT, 2 CHAR
//   o_x1,o_y1,o_x2,o_y2    RECT corners (CHAR uses o_x1/o_y1)
//   o_ys,o_ye              CLEAR row range
//   o_ascii, o_color       CHAR code, command colour
//   o_bank, o_disp_bank    bank being written, last completed bank
//   o_frame_done           one-cycle pulse when the list completes
//   o_overrun, i_overrun_clr sticky "start while busy" flag and its clear
// -----------------------------------------------------------------------------
module overlay_cmd_seq #(
  parameter int         N_RECT      = 16,
  parameter int         L_W         = 10,
  parameter int         CLS_W       = 4,
  parameter int         LBL_CH      = 8,
  parameter int         BANK_ROWS   = 128,
  parameter int         LBL_YOFF    = 10,
  parameter logic [2:0] RECT_COLOR  = 3'b011,
  parameter logic [2:0] LABEL_COLOR = 3'b010
) (
  input  logic                              sys_clk,
  input  logic                              sys_rst,
  input  logic                              i_frame_start,
  input  logic [N_RECT*4*L_W-1:0]           i_rect,
  input  logic [N_RECT-1:0]                 i_rect_vld,
  input  logic [N_RECT*CLS_W-1:0]           i_rect_cls,
  input  logic [(2**CLS_W)*LBL_CH*8-1:0]    i_cls_str,
  output logic                              o_cmd_valid,
  input  logic                              i_cmd_ready,
  output logic [1:0]                        o_cmd_type,
  output logic [L_W-1:0]                    o_x1,
  output logic [L_W-1:0]                    o_y1,
  output logic [L_W-1:0]                    o_x2,
  output logic [L_W-1:0]                    o_y2,
  output logic [L_W-1:0]                    o_ys,
  output logic [L_W-1:0]                    o_ye,
  output logic [7:0]                        o_ascii,
  output logic [2:0]                        o_color,
  output logic                              o_bank,
  output logic                              o_disp_bank,
  output logic                              o_frame_done,
  output logic                              o_overrun,
  input  logic                              i_overrun_clr
);

  localparam int BOX_W = 4 * L_W;
  localparam int KW    = (N_RECT > 1) ? $clog2(N_RECT) : 1;
  localparam logic [L_W:0] ROWS = (L_W+1)'(BANK_ROWS);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RECT, S_LABEL, S_DONE} state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic [N_RECT*BOX_W-1:0]  r_rect;
  logic [N_RECT-1:0]        r_vld;
  logic [KW-1:0]            r_k;
  logic                     r_bank;
  logic                     r_disp_bank;
  logic                     r_frame_done;
  logic                     r_overrun;

  logic [BOX_W-1:0]         w_box;
  logic [L_W-1:0]           w_x1, w_y1, w_x2, w_y2;
  logic [L_W:0]             w_ys_x, w_ye_x;
  logic                     w_xfer;
  logic                     w_k_last;
  logic                     w_rect_adv;
  logic                     w_k_ld;
  logic [KW-1:0]            w_k_nxt;

  // Coordinates are carried one bit wider; anything past the top is clamped.
  function automatic logic [L_W-1:0] f_sat(input logic [L_W:0] v);
    return v[L_W] ? {L_W{1'b1}} : v[L_W-1:0];
  endfunction

  // Subtraction that floors at zero instead of wrapping.
  function automatic logic [L_W-1:0] f_sub_floor(input logic [L_W-1:0] a,
                                                 input logic [L_W-1:0] b);
    return (a < b) ? '0 : (a - b);
  endfunction

  assign w_box      = r_rect[int'(r_k)*BOX_W +: BOX_W];
  assign w_x1       = w_box[4*L_W-1 -: L_W];
  assign w_y1       = w_box[3*L_W-1 -: L_W];
  assign w_x2       = w_box[2*L_W-1 -: L_W];
  assign w_y2       = w_box[L_W-1:0];
  assign w_ys_x     = r_bank ? ROWS : '0;
  assign w_ye_x     = w_ys_x + ROWS - (L_W+1)'(1);
  assign w_xfer     = o_cmd_valid & i_cmd_ready;
  assign w_k_last   = (int'(r_k) == N_RECT - 1);
  // Invalid slots advance on their own; valid slots wait for the handshake.
  assign w_rect_adv = !r_vld[r_k] || w_xfer;

`ifdef OVL_LABEL_EN
  localparam int IW = (LBL_CH > 1) ? $clog2(LBL_CH) : 1;
  localparam logic [L_W-1:0] YOFF = L_W'(LBL_YOFF);

  logic [N_RECT*CLS_W-1:0]  r_cls;
  logic [IW-1:0]            r_i;
  logic [7:0]               r_char;
  logic [L_W:0]             w_xc;
  logic                     w_emit;
  logic                     w_box_end;
  logic                     w_i_ld;
  logic [IW-1:0]            w_i_nxt;
  logic [CLS_W-1:0]         w_ncls;
  logic [7:0]               w_nchar;

  assign w_xc   = {1'b0, w_x1} + ((L_W+1)'(r_i) << 3);
  // A string stops at its terminator or at the first char off the right edge.
  assign w_emit = r_vld[r_k] && (r_char != 8'h00) && !w_xc[L_W];
  assign w_box_end = !w_emit || (w_xfer && (int'(r_i) == LBL_CH - 1));

  // The char for the next (box, index) is fetched when the indices move, so
  // the presented char is held even if the class table changes during a stall.
  always_comb begin
    w_i_ld  = 1'b0;
    w_i_nxt = r_i;
    if (r_state == S_RECT && w_rect_adv && w_k_last) begin
      w_i_ld  = 1'b1;
      w_i_nxt = '0;
    end else if (r_state == S_LABEL) begin
      if (w_box_end) begin
        w_i_ld  = 1'b1;
        w_i_nxt = '0;
      end else if (w_xfer) begin
        w_i_ld  = 1'b1;
        w_i_nxt = r_i + IW'(1);
      end
    end
  end

  assign w_ncls  = r_cls[int'(w_k_nxt)*CLS_W +: CLS_W];
  assign w_nchar = i_cls_str[int'(w_ncls)*LBL_CH*8 + (LBL_CH-1-int'(w_i_nxt))*8 +: 8];

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_i <= '0;
    end else if (w_i_ld) begin
      r_i <= w_i_nxt;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (r_state == S_IDLE && i_frame_start) r_cls <= i_rect_cls;
    if (w_i_ld) r_char <= w_nchar;
  end
`else
  logic w_unused_lbl;
  assign w_unused_lbl = ^{i_cls_str, i_rect_cls};
`endif

  // Box index walk shared by the RECT scan and the label pass.
  always_comb begin
    w_k_ld  = 1'b0;
    w_k_nxt = r_k;
    case (r_state)
      S_CLEAR: if (w_xfer) begin
        w_k_ld  = 1'b1;
        w_k_nxt = '0;
      end
      S_RECT: if (w_rect_adv) begin
        w_k_ld  = 1'b1;
        w_k_nxt = w_k_last ? '0 : (r_k + KW'(1));
      end
`ifdef OVL_LABEL_EN
      S_LABEL: if (w_box_end) begin
        w_k_ld  = 1'b1;
        w_k_nxt = r_k + KW'(1);
      end
`endif
      default: ;
    endcase
  end

  // ---- state register and control flags ----
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state      <= S_IDLE;
      r_k          <= '0;
      r_bank       <= 1'b0;
      r_disp_bank  <= 1'b1;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_state      <= w_next;
      if (w_k_ld) r_k <= w_k_nxt;
      r_frame_done <= (r_state == S_DONE);
      if (r_state == S_DONE) begin
        r_disp_bank <= r_bank;
        r_bank      <= ~r_bank;
      end
      // A fresh overrun beats a simultaneous clear.
      if (i_frame_start && r_state != S_IDLE) r_overrun <= 1'b1;
      else if (i_overrun_clr)                 r_overrun <= 1'b0;
    end
  end

  // Frame snapshot: later input changes cannot tear the frame in progress.
  always_ff @(posedge sys_clk) begin
    if (r_state == S_IDLE && i_frame_start) begin
      r_rect <= i_rect;
      r_vld  <= i_rect_vld;
    end
  end

  // ---- next-state logic ----
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_frame_start) w_next = S_CLEAR;
      S_CLEAR: if (w_xfer) w_next = S_RECT;
      S_RECT: if (w_rect_adv && w_k_last) begin
`ifdef OVL_LABEL_EN
        w_next = S_LABEL;
`else
        w_next = S_DONE;
`endif
      end
`ifdef OVL_LABEL_EN
      S_LABEL: if (w_box_end && w_k_last) w_next = S_DONE;
`endif
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // ---- command outputs ----
  always_comb begin
    o_cmd_valid = 1'b0;
    o_cmd_type  = 2'd0;
    o_x1        = '0;
    o_y1        = '0;
    o_x2        = '0;
    o_y2        = '0;
    o_ys        = '0;
    o_ye        = '0;
    o_ascii     = 8'h00;
    o_color     = 3'b000;
    case (r_state)
      S_CLEAR: begin
        o_cmd_valid = 1'b1;
        o_ys        = f_sat(w_ys_x);
        o_ye        = f_sat(w_ye_x);
      end
      S_RECT: if (r_vld[r_k]) begin
        o_cmd_valid = 1'b1;
        o_cmd_type  = 2'd1;
        o_x1        = w_x1;
        o_y1        = w_y1;
        o_x2        = w_x2;
        o_y2        = w_y2;
        o_color     = RECT_COLOR;
      end
`ifdef OVL_LABEL_EN
      S_LABEL: if (w_emit) begin
        o_cmd_valid = 1'b1;
        o_cmd_type  = 2'd2;
        o_x1        = w_xc[L_W-1:0];
        o_y1        = f_sub_floor(w_y1, YOFF);
        o_ascii     = r_char;
        o_color     = LABEL_COLOR;
      end
`endif
      default: ;
    endcase
  end

  assign o_bank       = r_bank;
  assign o_disp_bank  = r_disp_bank;
  assign o_frame_done = r_frame_done;
  assign o_overrun    = r_overrun;

endmodule
